cpu_controller: RTL and testbench

- Multi-cycle control unit on the issuing side of the ALU/datapath interface.
- Latches a 16-bit instruction, decodes it, and sequences datapath strobes: register read, A/B load, ALU operation select, C/status load, register write.
- It generates the ALUop code and operand routing that the ALU consumes.
- Sits between the instruction source (switches/memory) and the datapath in the simple RISC CPU.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/instr_decoder.sv | 48 ++++
 rtl/cpu_controller.sv | 156 +++++++++++++++
 tb/tb_cpu_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encoding constants for the simple RISC control unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_OPERATE, S_WRITE_REG, S_WRITE_IMM
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_MOV_IMM, CLS_MOV_REG, CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN
  } cls_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;
  localparam logic [1:0] MOV_IMM_OP = 2'b10;
  localparam logic [1:0] MOV_REG_OP = 2'b00;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IM8_HI = 7;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction and instruction classification for a 16-bit IR.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic [IW-1:0] ir,
  output logic [2:0]    rn,
  output logic [2:0]    rd,
  output logic [2:0]    rm,
  output logic [1:0]    sh,
  output logic [1:0]    op,
  output logic [IW-1:0] sximm8,
  output cls_t          cls,
  output logic          illegal
);

  assign rn      = ir[RN_HI:RN_LO];
  assign rd      = ir[RD_HI:RD_LO];
  assign rm      = ir[RM_HI:RM_LO];
  assign sh      = ir[SH_HI:SH_LO];
  assign op      = ir[OP_HI:OP_LO];
  assign sximm8  = sext8(ir[IM8_HI:0]);
  assign illegal = (cls == CLS_ILLEGAL);

  // Map opcode/op pairs onto the supported instruction classes.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (ir[OPC_HI:OPC_LO])
      OPC_MOV: begin
        if (op == MOV_IMM_OP)      cls = CLS_MOV_IMM;
        else if (op == MOV_REG_OP) cls = CLS_MOV_REG;
        else                       cls = CLS_ILLEGAL;
      end
      OPC_ALU: begin
        case (op)
          ALU_ADD:  cls = CLS_ADD;
          ALU_SUB:  cls = CLS_CMP;
          ALU_AND:  cls = CLS_AND;
          ALU_NOTB: cls = CLS_MVN;
          default:  cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: latches an instruction and sequences datapath strobes.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [IW-1:0] in,
  output logic          w,
  output logic          illegal,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          vsel,
  output logic [IW-1:0] sximm8,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic          loadc,
  output logic          loads
);

  state_t        state;
  logic [IW-1:0] ir;
  logic [IW-1:0] ir_next;
  logic [2:0]    dec_rn, dec_rd, dec_rm;
  logic [1:0]    dec_sh, dec_op;
  logic [IW-1:0] dec_sximm8;
  cls_t          dec_cls;
  logic          dec_illegal;

  // Decode the IR value that will be current next cycle, so every output can be registered.
  assign ir_next = (state == S_WAIT && load) ? in : ir;

  instr_decoder #(.IW(IW)) u_dec (
    .ir      (ir_next),
    .rn      (dec_rn),
    .rd      (dec_rd),
    .rm      (dec_rm),
    .sh      (dec_sh),
    .op      (dec_op),
    .sximm8  (dec_sximm8),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // State register, IR and registered Moore outputs for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_WAIT;
      ir       <= '0;
      w        <= 1'b1;
      illegal  <= 1'b0;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write    <= 1'b0;
      vsel     <= 1'b0;
      sximm8   <= '0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      shift    <= 2'b00;
      ALUop    <= 2'b00;
      loadc    <= 1'b0;
      loads    <= 1'b0;
    end else begin
      ir       <= ir_next;
      sximm8   <= dec_sximm8;
      w        <= 1'b0;
      illegal  <= 1'b0;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write    <= 1'b0;
      vsel     <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      shift    <= 2'b00;
      ALUop    <= 2'b00;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      case (state)
        S_WAIT: begin
          if (s) begin
            state   <= S_DECODE;
            illegal <= dec_illegal;
          end else begin
            state   <= S_WAIT;
            w       <= 1'b1;
          end
        end
        S_DECODE: begin
          case (dec_cls)
            CLS_MOV_IMM: begin
              state    <= S_WRITE_IMM;
              writenum <= dec_rn;
              vsel     <= 1'b1;
              write    <= 1'b1;
            end
            CLS_MOV_REG, CLS_MVN: begin
              state   <= S_GET_B;
              readnum <= dec_rm;
              loadb   <= 1'b1;
            end
            CLS_ADD, CLS_AND, CLS_CMP: begin
              state   <= S_GET_A;
              readnum <= dec_rn;
              loada   <= 1'b1;
            end
            default: begin
              state <= S_WAIT;
              w     <= 1'b1;
            end
          endcase
        end
        S_GET_A: begin
          state   <= S_GET_B;
          readnum <= dec_rm;
          loadb   <= 1'b1;
        end
        S_GET_B: begin
          state <= S_OPERATE;
          shift <= dec_sh;
          ALUop <= (dec_cls == CLS_MOV_REG) ? ALU_ADD : dec_op;
          asel  <= (dec_cls == CLS_MOV_REG) || (dec_cls == CLS_MVN);
          if (dec_cls == CLS_CMP) loads <= 1'b1;
          else                    loadc <= 1'b1;
        end
        S_OPERATE: begin
          if (dec_cls == CLS_CMP) begin
            state <= S_WAIT;
            w     <= 1'b1;
          end else begin
            state    <= S_WRITE_REG;
            writenum <= dec_rd;
            write    <= 1'b1;
          end
        end
        S_WRITE_REG, S_WRITE_IMM: begin
          state <= S_WAIT;
          w     <= 1'b1;
        end
        default: begin
          state <= S_WAIT;
          w     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench: each clock step queues the expected output vector, a negedge monitor compares.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, illegal, write, vsel, loada, loadb, asel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8;
  logic [1:0]  shift, ALUop;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic [15:0] sximm8;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        loadc;
    logic        loads;
  } outv_t;

  typedef struct {
    string name;
    outv_t v;
  } entry_t;

  entry_t q[$];
  entry_t ent;
  outv_t  act;
  int     checks = 0;
  int     errors = 0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .sximm8(sximm8), .loada(loada), .loadb(loadb),
    .asel(asel), .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads)
  );

  always #5 clk = ~clk;

  assign act = '{w, illegal, readnum, writenum, write, vsel, sximm8,
                 loada, loadb, asel, shift, ALUop, loadc, loads};

  // Monitor: every queued expectation is matched against the outputs of that cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      ent = q.pop_front();
      checks++;
      if (act !== ent.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", ent.name, act, ent.v);
      end
    end
  end

  function automatic outv_t base(input logic [15:0] sx);
    outv_t e = '0;
    e.sximm8 = sx;
    return e;
  endfunction

  task automatic step(input string nm, input outv_t e);
    @(posedge clk);
    #1;
    q.push_back('{nm, e});
  endtask

  task automatic x_wait(input string nm, input logic [15:0] sx);
    outv_t e = base(sx);
    e.w = 1'b1;
    step({nm, "/wait"}, e);
  endtask

  task automatic x_decode(input string nm, input logic [15:0] sx, input logic ill);
    outv_t e = base(sx);
    e.illegal = ill;
    step({nm, "/decode"}, e);
  endtask

  task automatic x_geta(input string nm, input logic [15:0] sx, input logic [2:0] rn);
    outv_t e = base(sx);
    e.readnum = rn;
    e.loada = 1'b1;
    step({nm, "/get_a"}, e);
  endtask

  task automatic x_getb(input string nm, input logic [15:0] sx, input logic [2:0] rm);
    outv_t e = base(sx);
    e.readnum = rm;
    e.loadb = 1'b1;
    step({nm, "/get_b"}, e);
  endtask

  task automatic x_op(input string nm, input logic [15:0] sx, input logic [1:0] sh,
                      input logic [1:0] alu, input logic as, input logic cmp);
    outv_t e = base(sx);
    e.shift = sh;
    e.aluop = alu;
    e.asel  = as;
    e.loads = cmp;
    e.loadc = ~cmp;
    step({nm, "/operate"}, e);
  endtask

  task automatic x_wr(input string nm, input logic [15:0] sx, input logic [2:0] rd,
                      input logic imm);
    outv_t e = base(sx);
    e.writenum = rd;
    e.vsel  = imm;
    e.write = 1'b1;
    step({nm, "/write"}, e);
  endtask

  task automatic launch(input logic [15:0] instr);
    load = 1'b1;
    in   = instr;
    s    = 1'b1;
  endtask

  task automatic idle_inputs();
    load = 1'b0;
    s    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    x_wait("reset0", 16'h0000);
    x_wait("reset1", 16'h0000);
    reset = 1'b0;

    // MOV R0,#-5
    launch(16'hD0FB);
    x_decode("movi", 16'hFFFB, 1'b0);
    idle_inputs();
    x_wr("movi", 16'hFFFB, 3'd0, 1'b1);
    x_wait("movi", 16'hFFFB);

    // ADD R2,R1,R0,LSL#1
    launch(16'hA148);
    x_decode("add", 16'h0048, 1'b0);
    idle_inputs();
    x_geta("add", 16'h0048, 3'd1);
    x_getb("add", 16'h0048, 3'd0);
    x_op("add", 16'h0048, 2'b01, 2'b00, 1'b0, 1'b0);
    x_wr("add", 16'h0048, 3'd2, 1'b0);
    x_wait("add", 16'h0048);

    // CMP R1,R0
    launch(16'hA900);
    x_decode("cmp", 16'h0000, 1'b0);
    idle_inputs();
    x_geta("cmp", 16'h0000, 3'd1);
    x_getb("cmp", 16'h0000, 3'd0);
    x_op("cmp", 16'h0000, 2'b00, 2'b01, 1'b0, 1'b1);
    x_wait("cmp", 16'h0000);

    // MVN R3,R0, with a load attempt during GET_B that must be ignored
    launch(16'hB860);
    x_decode("mvn", 16'h0060, 1'b0);
    idle_inputs();
    x_getb("mvn", 16'h0060, 3'd0);
    load = 1'b1;
    in   = 16'hD0FB;
    x_op("mvn", 16'h0060, 2'b00, 2'b11, 1'b1, 1'b0);
    idle_inputs();
    x_wr("mvn", 16'h0060, 3'd3, 1'b0);
    x_wait("mvn", 16'h0060);

    // AND R1,R2,R3
    launch(16'hB223);
    x_decode("and", 16'h0023, 1'b0);
    idle_inputs();
    x_geta("and", 16'h0023, 3'd2);
    x_getb("and", 16'h0023, 3'd3);
    x_op("and", 16'h0023, 2'b00, 2'b10, 1'b0, 1'b0);
    x_wr("and", 16'h0023, 3'd1, 1'b0);
    x_wait("and", 16'h0023);

    // MOV R4,R5,LSR#1, then s held high relaunches the latched IR
    launch(16'hC095);
    x_decode("movr", 16'hFF95, 1'b0);
    load = 1'b0;
    x_getb("movr", 16'hFF95, 3'd5);
    x_op("movr", 16'hFF95, 2'b10, 2'b00, 1'b1, 1'b0);
    x_wr("movr", 16'hFF95, 3'd4, 1'b0);
    x_wait("movr", 16'hFF95);
    x_decode("relaunch", 16'hFF95, 1'b0);
    s = 1'b0;
    x_getb("relaunch", 16'hFF95, 3'd5);
    x_op("relaunch", 16'hFF95, 2'b10, 2'b00, 1'b1, 1'b0);
    x_wr("relaunch", 16'hFF95, 3'd4, 1'b0);
    x_wait("relaunch", 16'hFF95);

    // Unsupported encoding
    launch(16'h0000);
    x_decode("illegal", 16'h0000, 1'b1);
    idle_inputs();
    x_wait("illegal", 16'h0000);

    // Reset during OPERATE aborts the ADD
    launch(16'hA148);
    x_decode("abort", 16'h0048, 1'b0);
    idle_inputs();
    x_geta("abort", 16'h0048, 3'd1);
    x_getb("abort", 16'h0048, 3'd0);
    x_op("abort", 16'h0048, 2'b01, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    x_wait("abort_rst", 16'h0000);
    reset = 1'b0;
    x_wait("abort_after", 16'h0000);
    x_wait("abort_idle", 16'h0000);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
